// File: rtl/wishbone_responder.sv
// Wishbone classic slave backed by a small word-addressed register file.
// Programmable wait states, err on illegal accesses, rty inside a post-write busy window.
module wishbone_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          DEPTH_LOG2  = 6,
    parameter int          WAIT_STATES = 2,
    parameter int          BUSY_CYCLES = 4,
    parameter logic [31:0] ID_VALUE    = 32'h5752_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] adr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        cyc,
    input  logic        stb,
    input  logic [3:0]  sel,
    input  logic        we,
    output logic        ack,
    output logic        err,
    output logic        rty
);

    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    localparam int          IDX_W     = DEPTH_LOG2;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);
    localparam logic [15:0] BUSY_LOAD = 16'(BUSY_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_reg;
    logic [3:0]  wait_cnt_reg;
    logic [15:0] busy_cnt_reg;

    logic [31:0] adr_reg;
    logic [31:0] din_reg;
    logic [3:0]  sel_reg;
    logic        we_reg;

    logic        ack_reg;
    logic        err_reg;
    logic        rty_reg;
    logic [31:0] dout_reg;

    // With zero wait states the response is decided on the accept edge itself,
    // so the request is taken straight from the bus instead of the latches.
    logic [31:0] req_adr;
    logic [31:0] req_din;
    logic [3:0]  req_sel;
    logic        req_we;
    logic [IDX_W-1:0] req_idx;

    logic accept;
    logic respond;
    logic in_window;
    logic misaligned;
    logic is_err;
    logic is_rty;
    logic is_ack;
    logic commit;

    logic [DEPTH-1:0][31:0] words;
    logic [31:0]            rd_word;

    always_comb begin
        req_adr = adr_reg;
        req_din = din_reg;
        req_sel = sel_reg;
        req_we  = we_reg;
        if (state_reg == ST_IDLE) begin
            req_adr = adr;
            req_din = din;
            req_sel = sel;
            req_we  = we;
        end
    end

    assign req_idx    = req_adr[DEPTH_LOG2+1:2];
    assign in_window  = (req_adr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
    assign misaligned = (req_adr[1:0] != 2'b00);

    assign accept  = (state_reg == ST_IDLE) && cyc && stb;
    assign respond = ((WAIT_STATES == 0) && accept) ||
                     ((state_reg == ST_WAIT) && cyc && (wait_cnt_reg == 4'd1));

    // The busy count seen during the response cycle is one less than the
    // current value, so a read is retried only while more than one remains.
    always_comb begin
        is_err = !in_window || misaligned || (req_sel == 4'b0000) ||
                 (req_we && (req_idx == '0));
        is_rty = !is_err && !req_we && (busy_cnt_reg > 16'd1);
        is_ack = !is_err && !is_rty;
    end

    assign commit  = respond && is_ack && req_we;
    assign rd_word = words[req_idx];

    assign words[0] = ID_VALUE;

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_word
            logic [31:0] word_q;
            logic        wr_en;

            assign wr_en     = commit && (req_idx == IDX_W'(gi));
            assign words[gi] = word_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    word_q <= '0;
                end else if (wr_en) begin
                    for (int b = 0; b < 4; b++) begin
                        if (req_sel[b]) begin
                            word_q[8*b +: 8] <= req_din[8*b +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            adr_reg      <= '0;
            din_reg      <= '0;
            sel_reg      <= '0;
            we_reg       <= 1'b0;
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
            rty_reg      <= 1'b0;
            dout_reg     <= '0;
        end else begin
            ack_reg  <= 1'b0;
            err_reg  <= 1'b0;
            rty_reg  <= 1'b0;
            dout_reg <= '0;

            if (respond) begin
                ack_reg <= is_ack;
                err_reg <= is_err;
                rty_reg <= is_rty;
                if (is_ack && !req_we) begin
                    dout_reg <= rd_word;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        adr_reg      <= adr;
                        din_reg      <= din;
                        sel_reg      <= sel;
                        we_reg       <= we;
                        wait_cnt_reg <= WAIT_LOAD;
                        state_reg    <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Only cyc aborts; a dropped stb mid-wait is ignored.
                    if (!cyc) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                        if (wait_cnt_reg == 4'd1) begin
                            state_reg <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt_reg <= '0;
        end else if (commit) begin
            busy_cnt_reg <= BUSY_LOAD;
        end else if (busy_cnt_reg != 16'd0) begin
            busy_cnt_reg <= busy_cnt_reg - 16'd1;
        end
    end

    assign ack  = ack_reg;
    assign err  = err_reg;
    assign rty  = rty_reg;
    assign dout = dout_reg;

endmodule

// File: tb/tb_wishbone_responder.sv
// Directed and randomized bus transactions against wishbone_responder, checked
// against a register-file model that tracks the busy window by response cycle.
module tb_wishbone_responder;

    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam int          DLOG2  = 6;
    localparam int          WS     = 2;
    localparam int          BUSY   = 6;
    localparam logic [31:0] ID     = 32'h5752_0001;
    localparam int          NWORDS = 1 << DLOG2;
    localparam logic [31:0] WIN    = 32'(4 * NWORDS);

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        cyc;
    logic        stb;
    logic [3:0]  sel;
    logic        we;
    logic        ack;
    logic        err;
    logic        rty;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;
    int txn_no = 0;

    logic [31:0] mem [NWORDS];
    int          last_wr;

    wishbone_responder #(
        .BASE_ADDR  (BASE),
        .DEPTH_LOG2 (DLOG2),
        .WAIT_STATES(WS),
        .BUSY_CYCLES(BUSY),
        .ID_VALUE   (ID)
    ) dut (
        .clk (clk),
        .rst (rst),
        .adr (adr),
        .din (din),
        .dout(dout),
        .cyc (cyc),
        .stb (stb),
        .sel (sel),
        .we  (we),
        .ack (ack),
        .err (err),
        .rty (rty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NWORDS; i++) mem[i] = '0;
        last_wr = -1000;
    endtask

    // Returns {ack, err, rty} for a request whose response lands on resp_edge.
    function automatic logic [2:0] exp_kind(input logic [31:0] a, input logic [3:0] s,
                                            input logic w, input int resp_edge);
        bit e, r, in_win;
        in_win = (a >= BASE) && (a < BASE + WIN);
        e = !in_win || (a % 4 != 0) || (s == 4'b0) || (w && (a - BASE) < 4);
        r = !e && !w && (resp_edge - last_wr >= 1) && (resp_edge - last_wr < BUSY);
        return {!e && !r, e, r};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Caller is at a negedge with the DUT idle; returns one negedge after the response.
    task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic w, output logic [2:0] kind, output logic [31:0] rdata);
        int acc, k, idx;
        logic [2:0]  ek;
        logic [31:0] ed;
        adr = a; din = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        acc = edge_cnt;
        k = 0;
        while (!(ack || err || rty) && k < 20) begin
            @(negedge clk);
            k++;
        end
        kind  = {ack, err, rty};
        rdata = dout;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        txn_no++;

        ek  = exp_kind(a, s, w, acc + WS);
        idx = int'((a - BASE) >> 2) % NWORDS;
        ed  = '0;
        if (ek[2] && !w) ed = (idx == 0) ? ID : mem[idx];
        $display("[TB] txn %0d %s adr=%h din=%h sel=%b -> ack/err/rty=%b dout=%h (latency %0d)",
                 txn_no, w ? "WR" : "RD", a, d, s, kind, rdata, k);
        chk($sformatf("txn%0d_kind", txn_no), {29'b0, kind}, {29'b0, ek});
        chk($sformatf("txn%0d_dout", txn_no), rdata, ed);
        chk($sformatf("txn%0d_latency", txn_no), 32'(k), 32'(WS));
        if (ek[2] && w) begin
            for (int b = 0; b < 4; b++) if (s[b]) mem[idx][8*b +: 8] = d[8*b +: 8];
            last_wr = acc + WS;
        end
        @(negedge clk);
        chk($sformatf("txn%0d_single_cycle", txn_no), {29'b0, ack, err, rty}, 32'b0);
    endtask

    task automatic expect_silence(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(tag, {29'b0, ack, err, rty}, 32'b0);
        end
    endtask

    initial begin
        logic [2:0]  kind;
        logic [31:0] rd;
        logic [31:0] a;

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; din = '0; sel = '0;
        model_reset();
        idle(3);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("reset_idle", {ack, err, rty, dout[28:0]} | {3'b0, 29'(dout >> 29)}, 32'b0);
        end

        txn(32'h1000, '0, 4'hF, 1'b0, kind, rd);
        chk("id_read", rd, 32'h5752_0001);

        txn(32'h1004, 32'hDEAD_BEEF, 4'hF, 1'b1, kind, rd);
        idle(10);
        txn(32'h1004, '0, 4'hF, 1'b0, kind, rd);
        chk("rd_deadbeef", rd, 32'hDEAD_BEEF);
        txn(32'h1004, 32'h0000_0011, 4'b0001, 1'b1, kind, rd);
        idle(10);
        txn(32'h1004, '0, 4'hF, 1'b0, kind, rd);
        chk("rd_byte_lane", rd, 32'hDEAD_BE11);

        txn(32'h1008, 32'h1234_5678, 4'hF, 1'b1, kind, rd);
        txn(32'h1008, '0, 4'hF, 1'b0, kind, rd);
        chk("busy_first_rty", {29'b0, kind}, 32'b001);
        for (int i = 0; i < 10 && kind != 3'b100; i++) txn(32'h1008, '0, 4'hF, 1'b0, kind, rd);
        chk("busy_eventual_ack", {29'b0, kind}, 32'b100);
        chk("busy_ack_data", rd, 32'h1234_5678);

        idle(10);
        txn(32'h2000, '0, 4'hF, 1'b0, kind, rd);
        chk("err_out_of_window", {29'b0, kind}, 32'b010);
        txn(32'h1000, 32'hFFFF_FFFF, 4'hF, 1'b1, kind, rd);
        chk("err_write_id", {29'b0, kind}, 32'b010);
        txn(32'h1000, '0, 4'hF, 1'b0, kind, rd);
        chk("id_unchanged", rd, 32'h5752_0001);
        txn(32'h1006, '0, 4'hF, 1'b0, kind, rd);
        chk("err_misaligned", {29'b0, kind}, 32'b010);
        txn(32'h1004, '0, 4'h0, 1'b0, kind, rd);
        chk("err_sel_zero", {29'b0, kind}, 32'b010);

        // Abort: drop cyc right after the accept edge.
        adr = 32'h100C; din = 32'hAAAA_5555; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        expect_silence("abort_silent", WS + 3);
        idle(10);
        txn(32'h100C, '0, 4'hF, 1'b0, kind, rd);
        chk("abort_no_write", rd, 32'h0);

        // Reset while a write to 0x1010 is waiting.
        adr = 32'h1010; din = 32'h0BAD_F00D; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        model_reset();
        expect_silence("reset_in_wait_silent", WS + 3);
        txn(32'h1010, '0, 4'hF, 1'b0, kind, rd);
        chk("after_reset_ack", {29'b0, kind}, 32'b100);
        chk("after_reset_zero", rd, 32'h0);
        txn(32'h1004, '0, 4'hF, 1'b0, kind, rd);
        chk("reset_cleared_word", rd, 32'h0);

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0: a = BASE + WIN + 32'($urandom_range(0, 255) * 4);
                1: a = BASE + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(1, 3));
                default: a = BASE + 32'($urandom_range(0, 7) * 4);
            endcase
            txn(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), kind, rd);
            idle($urandom_range(0, 6));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
